multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 150 +++++++++++++++
 tb/tb_multdiv_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit (sign-magnitude, one bit per cycle) for the execute stage.
// Optional macro MULTDIV_EARLY_DIV0_EN: divide-by-zero skips the iterations and completes at once.
`timescale 1ns/1ps

module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [31:0]      insn_in,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             data_ready,
  output logic             busy,
  output logic             stall,
  output logic [31:0]      insn_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mag_b;
  logic             negate;
  logic             div_zero;
  logic             div_ovf;

  logic             start;
  logic             last;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic             mult_ovf;
  logic [WIDTH-1:0] quot;

  assign start = (state == IDLE) && (ctrl_mult || ctrl_div);
  assign busy  = (state != IDLE);
  // DONE is excluded so the X/M latch can capture the result in that cycle.
  assign stall = (state == MULT) || (state == DIV) || start;
  assign last  = (count == CW'(WIDTH));

  assign abs_a = operandA[WIDTH-1] ? -operandA : operandA;
  assign abs_b = operandB[WIDTH-1] ? -operandB : operandB;

  // Multiply: {hi,lo} holds partial product in hi and the remaining multiplier bits in lo.
  assign mult_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign div_trial = {hi, lo[WIDTH-1]};
  assign div_fits  = (div_trial >= {1'b0, mag_b});
  assign div_rem   = div_trial[WIDTH-1:0] - mag_b;

  assign prod_mag = {hi, lo};
  assign prod     = negate ? -prod_mag : prod_mag;
  assign mult_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
  assign quot     = negate ? -lo : lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      mag_b      <= '0;
      negate     <= 1'b0;
      div_zero   <= 1'b0;
      div_ovf    <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      data_ready <= 1'b0;
      insn_out   <= '0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count     <= '0;
            hi        <= '0;
            lo        <= abs_a;
            mag_b     <= abs_b;
            negate    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
            div_zero  <= (operandB == '0);
            div_ovf   <= (operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (operandB == '1);
            exception <= 1'b0;
            insn_out  <= insn_in;
            if (ctrl_mult) begin
              state <= MULT;
            end else begin
`ifdef MULTDIV_EARLY_DIV0_EN
              if (operandB == '0) begin
                state      <= DONE;
                result     <= '0;
                exception  <= 1'b1;
                data_ready <= 1'b1;
              end else begin
                state <= DIV;
              end
`else
              state <= DIV;
`endif
            end
          end
        end
        MULT: begin
          if (last) begin
            state      <= DONE;
            result     <= prod[WIDTH-1:0];
            exception  <= mult_ovf;
            data_ready <= 1'b1;
          end else begin
            count      <= count + 1'b1;
            {hi, lo}   <= {mult_sum, lo[WIDTH-1:1]};
          end
        end
        DIV: begin
          if (last) begin
            state      <= DONE;
            result     <= div_zero ? '0 : quot;
            exception  <= div_zero | div_ovf;
            data_ready <= 1'b1;
          end else begin
            count <= count + 1'b1;
            hi    <= div_fits ? div_rem : div_trial[WIDTH-1:0];
            lo    <= {lo[WIDTH-2:0], div_fits};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected results are queued at start and compared on data_ready.
`timescale 1ns/1ps

module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] insn_in;
  logic [31:0] result;
  logic        exception;
  logic        data_ready;
  logic        busy;
  logic        stall;
  logic [31:0] insn_out;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] insn;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operandA   (operandA),
    .operandB   (operandB),
    .insn_in    (insn_in),
    .result     (result),
    .exception  (exception),
    .data_ready (data_ready),
    .busy       (busy),
    .stall      (stall),
    .insn_out   (insn_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference behaviour from plain signed arithmetic.
  function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic x);
    longint p;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      x = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      x = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      x = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      x = 1'b0;
    end
  endfunction

  // Latency = posedges after the start edge until data_ready is seen at a falling edge.
  always @(negedge clock) begin
    if (reset_n && data_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", data_ready, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("exception", exception, mon_e.exc);
        check("insn_out", insn_out, mon_e.insn);
        check("latency", cyc - mon_e.start_cyc, mon_e.lat);
        check("stall_in_done", stall, 1'b0);
        check("busy_in_done", busy, 1'b1);
        $display("txn insn=%08h result=%08h exc=%0d latency=%0d", insn_out, result, exception,
                 cyc - mon_e.start_cyc);
      end
    end
  end

  // Called at a falling edge with the DUT idle.
  task automatic drive_start(input logic m, input logic d, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] insn);
    exp_t e;
    ctrl_mult = m;
    ctrl_div  = d;
    operandA  = a;
    operandB  = b;
    insn_in   = insn;
    model(m, a, b, e.res, e.exc);
    e.insn = insn;
    e.lat  = 33;
`ifdef MULTDIV_EARLY_DIV0_EN
    if (!m && b == 32'd0) e.lat = 0;
`endif
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    #1;
    check("stall_on_start", stall, 1'b1);
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operandA  = $urandom;
    operandB  = $urandom;
    insn_in   = $urandom;
  endtask

  task automatic wait_done(input int pulse_at);
    int stall_low = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (data_ready) begin
        seen = 1'b1;
      end else begin
        if (!stall) stall_low++;
        if (i == pulse_at) begin
          ctrl_div = 1'b1;
          operandA = 32'd100;
          operandB = 32'd0;
        end else begin
          ctrl_div = 1'b0;
        end
      end
    end
    ctrl_div = 1'b0;
    check("done_seen", seen, 1'b1);
    check("stall_held", stall_low, 0);
    @(negedge clock);
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] insn, input int pulse_at);
    drive_start(m, d, a, b, insn);
    wait_done(pulse_at);
  endtask

  initial begin
    int ready_cnt;
    logic        rm;
    logic [31:0] ra;
    logic [31:0] rb;
    reset_n   = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operandA  = '0;
    operandB  = '0;
    insn_in   = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_result", result, 32'd0);
    check("rst_exception", exception, 1'b0);
    check("rst_ready", data_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_insn", insn_out, 32'd0);
    check("rst_stall", stall, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'h1111_1111, -1);
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h2222_2222, -1);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h3333_3333, -1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4444_4444, -1);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 32'h5555_5555, -1);
    run_op(1'b1, 1'b0, 32'hFFFE_1DC0, 32'd789, 32'h6666_6666, 5);
    run_op(1'b1, 1'b1, 32'd1000, 32'hFFFF_FFFD, 32'h7777_7777, -1);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8888_8888, -1);

    for (int i = 0; i < 6; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(1, 30);
      run_op(rm, ~rm, ra, rb, $urandom, -1);
    end

    // Reset in the middle of a multiply discards it.
    drive_start(1'b1, 1'b0, 32'd12345, 32'd678, 32'h9999_9999);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_exception", exception, 1'b0);
    check("midrst_ready", data_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_insn", insn_out, 32'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    ready_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_ready) ready_cnt++;
    end
    check("midrst_no_ready", ready_cnt, 0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 32'hAAAA_AAAA, -1);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
